// File: rtl/fpu_pkg.sv
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared constants for the FPU multiply pipeline and its
//                result buffer: default field widths, multiplier latency,
//                result flag bit positions and canonical special values.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fpu_pkg;

    // Default single-precision layout (fraction includes the implicit bit)
    localparam int FRAC_WIDTH_DEF = 24;
    localparam int EXP_WIDTH_DEF  = 8;

    // Fixed multiplier pipeline depth, issue strobe to validOut
    localparam int MUL_LATENCY    = 10;

    // Result classification flags, packed {nan, inf, zero, subnormal}
    localparam int FLAG_WIDTH     = 4;
    localparam int FLAG_NAN       = 3;
    localparam int FLAG_INF       = 2;
    localparam int FLAG_ZERO      = 1;
    localparam int FLAG_SUB       = 0;

    // Canonical special encodings produced by the multiplier
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF   = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF   = 32'hFF80_0000;

endpackage

`default_nettype wire

// File: rtl/fpu_sync_fifo.sv
// ============================================================================
//  Module      : fpu_sync_fifo
//  Description : Synchronous FIFO with registered storage and combinational
//                head read. Pointers wrap modulo DEPTH (any DEPTH >= 1).
//                When empty, the read port holds the last popped head.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fpu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             rd_ok;
    logic             wr_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // A pop frees a slot in the same cycle, so a write into a full FIFO is
    // accepted when it coincides with a pop.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // No write-to-read bypass: a freshly written entry is visible next cycle
    assign rd_data = empty ? last_head : mem[rd_ptr];

    // Storage array and the held copy of the most recently popped head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            last_head <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
            end
            if (rd_ok) begin
                last_head <= mem[rd_ptr];
            end
        end
    end

    // Pointer wrap and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_mul_result_buffer.sv
// ============================================================================
//  Module      : fpu_mul_result_buffer
//  Description : Result FIFO behind the fixed-latency FPU multiplier. Hands
//                out issue credits so every issued operation has a guaranteed
//                slot, presents results valid/ready, and flags protocol abuse.
//                Optional macro FPU_RESULT_FLAGS_EN adds a per-entry
//                {nan, inf, zero, subnormal} flag field and port outFlagsOut.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fpu_mul_result_buffer
    import fpu_pkg::*;
#(
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
    parameter int EXP_WIDTH  = EXP_WIDTH_DEF,
    parameter int DEPTH      = 16,
    localparam int DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH,
    localparam int CRED_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clkIn,
    input  logic                  rstNIn,
    input  logic                  issueValidIn,
    output logic                  issueReadyOut,
    input  logic [DATA_WIDTH-1:0] resDataIn,
    input  logic                  resValidIn,
    output logic [DATA_WIDTH-1:0] outDataOut,
    output logic                  outValidOut,
    input  logic                  outReadyIn,
    output logic                  errOut,
    output logic [CRED_W-1:0]     inFlightOut
`ifdef FPU_RESULT_FLAGS_EN
    ,
    output logic [FLAG_WIDTH-1:0] outFlagsOut
`endif
);

`ifdef FPU_RESULT_FLAGS_EN
    localparam int ENTRY_W = DATA_WIDTH + FLAG_WIDTH;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [CRED_W-1:0]  credits;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               issue;
    logic               pop;

    assign issueReadyOut = (credits != '0);
    assign outValidOut   = ~fifo_empty;
    assign issue         = issueValidIn & issueReadyOut;
    assign pop           = outValidOut & outReadyIn;
    assign inFlightOut   = CRED_W'(DEPTH) - credits;

`ifdef FPU_RESULT_FLAGS_EN
    logic [EXP_WIDTH-1:0]  res_exp;
    logic [FRAC_WIDTH-2:0] res_man;
    logic [FLAG_WIDTH-1:0] res_flags;

    assign res_exp = resDataIn[DATA_WIDTH-2 -: EXP_WIDTH];
    assign res_man = resDataIn[FRAC_WIDTH-2:0];

    // Classify the incoming result so the flags travel with the data
    always_comb begin
        res_flags            = '0;
        res_flags[FLAG_NAN]  = (&res_exp) & (|res_man);
        res_flags[FLAG_INF]  = (&res_exp) & ~(|res_man);
        res_flags[FLAG_ZERO] = ~(|res_exp) & ~(|res_man);
        res_flags[FLAG_SUB]  = ~(|res_exp) & (|res_man);
    end

    assign wr_entry    = {res_flags, resDataIn};
    assign outFlagsOut = head_entry[ENTRY_W-1 -: FLAG_WIDTH];
`else
    assign wr_entry    = resDataIn;
`endif

    assign outDataOut = head_entry[DATA_WIDTH-1:0];

    fpu_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clkIn),
        .rst_n   (rstNIn),
        .wr_en   (resValidIn),
        .wr_data (wr_entry),
        .rd_en   (outReadyIn),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Credit counter: one credit per free result slot not yet promised.
    // Returns are clamped at DEPTH so a stray unissued write cannot overflow.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            credits <= CRED_W'(DEPTH);
        end else begin
            case ({issue, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= (credits != CRED_W'(DEPTH)) ? credits + 1'b1 : credits;
                default: credits <= credits;
            endcase
        end
    end

    // Sticky error: issue without credit, or a result arriving with no room
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            errOut <= 1'b0;
        end else if ((issueValidIn & ~issueReadyOut) | (resValidIn & fifo_full & ~pop)) begin
            errOut <= 1'b1;
        end
    end

endmodule

`default_nettype wire
